// File: rtl/hub75_pkg.sv
// Shared geometry, pixel/row types and row-address helper for the HUB75 capture model.
package hub75_pkg;

  localparam int COLS  = 32;
  localparam int SCAN  = 8;
  localparam int ABC_W = $clog2(SCAN);
  localparam int ROW_W = $clog2(2 * SCAN);
  localparam int COL_W = $clog2(COLS);

  typedef logic [2:0] rgb3_t;
  typedef rgb3_t [COLS-1:0] row_t;

  // Row address the driver is expected to latch after a.
  function automatic logic [ABC_W-1:0] next_abc(input logic [ABC_W-1:0] a);
    return (a == ABC_W'(SCAN - 1)) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/hub75_row_shifter.sv
// COLS-deep 3-bit shift register; entry 0 holds the newest sample, snap exposes all entries.
module hub75_row_shifter
  import hub75_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  rgb3_t din,
  output row_t  snap
);

  row_t sr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_reg <= '0;
    end else begin
      sr_reg <= {sr_reg[COLS-2:0], din};
    end
  end

  assign snap = sr_reg;

endmodule

// File: rtl/hub75_capture.sv
// Receive-side HUB75 panel model: deserialises rgb/lat/abc into a frame buffer,
// checks row-scan order and counts completed frames.
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        rgb_in,
  input  logic              lat_in,
  input  logic [ABC_W-1:0]  abc_in,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [2:0]        rd_rgb,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_count,
  output logic              seq_err,
  input  logic              clr_err
);

  row_t top_snap;
  row_t bot_snap;

  hub75_row_shifter u_top_shifter (
    .clk   (clk),
    .reset (reset),
    .din   (rgb_in[5:3]),
    .snap  (top_snap)
  );

  hub75_row_shifter u_bot_shifter (
    .clk   (clk),
    .reset (reset),
    .din   (rgb_in[2:0]),
    .snap  (bot_snap)
  );

  // Rows 0..SCAN-1 come from the top shifter, SCAN..2*SCAN-1 from the bottom one.
  // Nonblocking update means a latch takes the pre-shift snapshot of that edge.
  row_t fb_reg [2*SCAN];

  for (genvar gi = 0; gi < 2 * SCAN; gi++) begin : g_fb_row
    logic row_hit;
    assign row_hit = lat_in && (abc_in == ABC_W'(gi % SCAN));

    always_ff @(posedge clk) begin
      if (reset) begin
        fb_reg[gi] <= '0;
      end else if (row_hit) begin
        if (gi < SCAN) begin
          fb_reg[gi] <= top_snap;
        end else begin
          fb_reg[gi] <= bot_snap;
        end
      end
    end
  end

  rgb3_t rd_rgb_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_rgb_reg <= '0;
    end else begin
      rd_rgb_reg <= fb_reg[rd_row][rd_col];
    end
  end

  logic              first_latch_reg;
  logic [ABC_W-1:0]  last_abc_reg;
  logic              seq_err_reg;
  logic              frame_done_reg;
  logic [FCNT_W-1:0] frame_count_reg;
  logic              seq_mismatch;
  logic              frame_end;

  assign seq_mismatch = lat_in && !first_latch_reg && (abc_in != next_abc(last_abc_reg));
  assign frame_end    = lat_in && (abc_in == ABC_W'(SCAN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      first_latch_reg <= 1'b1;
      last_abc_reg    <= '0;
      seq_err_reg     <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      frame_done_reg <= frame_end;
      if (frame_end) begin
        frame_count_reg <= frame_count_reg + FCNT_W'(1);
      end
      // A new mismatch outranks a clear on the same edge.
      if (seq_mismatch) begin
        seq_err_reg <= 1'b1;
      end else if (clr_err) begin
        seq_err_reg <= 1'b0;
      end
      if (lat_in) begin
        last_abc_reg    <= abc_in;
        first_latch_reg <= 1'b0;
      end
    end
  end

  assign rd_rgb      = rd_rgb_reg;
  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;
  assign seq_err     = seq_err_reg;

endmodule
